sdram_slot_arbiter: RTL

//  Shares the single 8 MHz SDRAM access slot between three requesters: video fetch (P0), CPU (P1) and

---
 rtl/sdram_slot_arbiter_if.sv | 47 ++++
 rtl/sdram_slot_arbiter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/sdram_slot_arbiter_if.sv
// Requester-side and SDRAM-controller-side signals of the slot arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the sdram dout return.
interface sdram_slot_arbiter_if #(
  parameter int AW = 24,
  parameter int DW = 16
);
  logic          p0_req;
  logic [AW-1:0] p0_addr;
  logic          p1_req;
  logic          p1_we;
  logic [AW-1:0] p1_addr;
  logic [1:0]    p1_ds;
  logic [DW-1:0] p1_din;
  logic          p2_req;
  logic          p2_we;
  logic [AW-1:0] p2_addr;
  logic [1:0]    p2_ds;
  logic [DW-1:0] p2_din;
  logic          p0_ack;
  logic          p1_ack;
  logic          p2_ack;
  logic [DW-1:0] rdata;
  logic [AW-1:0] sd_addr_o;
  logic [DW-1:0] sd_din_o;
  logic [1:0]    sd_ds_o;
  logic          sd_oe_o;
  logic          sd_we_o;
  logic [DW-1:0] sd_dout_i;

  modport slave (
    input  p0_req, p0_addr,
    input  p1_req, p1_we, p1_addr, p1_ds, p1_din,
    input  p2_req, p2_we, p2_addr, p2_ds, p2_din,
    input  sd_dout_i,
    output p0_ack, p1_ack, p2_ack, rdata,
    output sd_addr_o, sd_din_o, sd_ds_o, sd_oe_o, sd_we_o
  );

  modport master (
    output p0_req, p0_addr,
    output p1_req, p1_we, p1_addr, p1_ds, p1_din,
    output p2_req, p2_we, p2_addr, p2_ds, p2_din,
    output sd_dout_i,
    input  p0_ack, p1_ack, p2_ack, rdata,
    input  sd_addr_o, sd_din_o, sd_ds_o, sd_oe_o, sd_we_o
  );
endinterface

// File: rtl/sdram_slot_arbiter.sv
// Grants one of video/CPU/DMA per 8-cycle SDRAM slot; ack in ph7 of the slot, requesters hold req until ack.
// Optional SDRAM_ARB_RR_EN: round-robin between P1/P2 (default fixed P0 > P1 > P2).
module sdram_slot_arbiter #(
  parameter int AW          = 24,
  parameter int DW          = 16,
  parameter int REFRESH_MAX = 8
) (
  input  logic                 clk_64,
  input  logic                 rst_n,
  input  logic                 clk_8,
  sdram_slot_arbiter_if.slave  bus
);
  localparam logic [1:0] GNT_NONE   = 2'd3;
  localparam logic [3:0] BUSY_LIMIT = 4'(REFRESH_MAX);

  logic [2:0]    ph, ph_nxt;
  logic [1:0]    gnt, gnt_nxt, win;
  logic [3:0]    busy_cnt, busy_nxt;
  logic [2:0]    ack_q, ack_nxt, elig;
  logic          arb_edge, cap_edge;
  logic [AW-1:0] sd_addr_q, sel_addr;
  logic [DW-1:0] sd_din_q, sel_din, rdata_q;
  logic [1:0]    sd_ds_q, sel_ds;
  logic          sd_oe_q, sd_we_q, sel_we;

  // A port acked this cycle is masked so a requester dropping req is not granted twice.
  assign elig     = {bus.p2_req, bus.p1_req, bus.p0_req} & ~ack_q;
  assign arb_edge = (ph == 3'd7) && !clk_8;
  assign cap_edge = (ph == 3'd6);

`ifdef SDRAM_ARB_RR_EN
  logic rr_ptr;  // 0 favours P1, 1 favours P2

  always_ff @(posedge clk_64 or negedge rst_n) begin
    if (!rst_n)                           rr_ptr <= 1'b0;
    else if (arb_edge && gnt_nxt == 2'd1) rr_ptr <= 1'b1;
    else if (arb_edge && gnt_nxt == 2'd2) rr_ptr <= 1'b0;
  end

  always_comb begin
    win = GNT_NONE;
    if (elig[0])                              win = 2'd0;
    else if (elig[1] && (!rr_ptr || !elig[2])) win = 2'd1;
    else if (elig[2])                         win = 2'd2;
  end
`else
  always_comb begin
    win = GNT_NONE;
    if (elig[0])      win = 2'd0;
    else if (elig[1]) win = 2'd1;
    else if (elig[2]) win = 2'd2;
  end
`endif

  // Phase locks to clk_8: parks at 7 while it is high and at 0 while it is low.
  always_comb begin
    ph_nxt = ph + 3'd1;
    if ((ph == 3'd7 && clk_8) || (ph == 3'd0 && !clk_8)) ph_nxt = ph;
  end

  always_comb begin
    gnt_nxt  = gnt;
    busy_nxt = busy_cnt;
    if (arb_edge) begin
      if (busy_cnt == BUSY_LIMIT) begin
        gnt_nxt  = GNT_NONE;
        busy_nxt = 4'd0;
      end else begin
        gnt_nxt  = win;
        busy_nxt = (win == GNT_NONE) ? 4'd0 : busy_cnt + 4'd1;
      end
    end
  end

  always_comb begin
    ack_nxt = 3'b000;
    if (cap_edge) begin
      case (gnt)
        2'd0:    ack_nxt = 3'b001;
        2'd1:    ack_nxt = 3'b010;
        2'd2:    ack_nxt = 3'b100;
        default: ack_nxt = 3'b000;
      endcase
    end
  end

  // Winner's qualifiers; video is read-only with both strobes and no write data.
  always_comb begin
    sel_addr = bus.p0_addr;
    sel_din  = sd_din_q;
    sel_ds   = 2'b11;
    sel_we   = 1'b0;
    case (gnt_nxt)
      2'd1: begin
        sel_addr = bus.p1_addr;
        sel_din  = bus.p1_din;
        sel_ds   = bus.p1_ds;
        sel_we   = bus.p1_we;
      end
      2'd2: begin
        sel_addr = bus.p2_addr;
        sel_din  = bus.p2_din;
        sel_ds   = bus.p2_ds;
        sel_we   = bus.p2_we;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_64 or negedge rst_n) begin
    if (!rst_n) begin
      ph        <= 3'd0;
      gnt       <= GNT_NONE;
      busy_cnt  <= 4'd0;
      ack_q     <= 3'b000;
      sd_addr_q <= '0;
      sd_din_q  <= '0;
      sd_ds_q   <= 2'b00;
      sd_oe_q   <= 1'b0;
      sd_we_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      ph       <= ph_nxt;
      gnt      <= gnt_nxt;
      busy_cnt <= busy_nxt;
      ack_q    <= ack_nxt;
      if (arb_edge) begin
        sd_oe_q <= (gnt_nxt != GNT_NONE) && !sel_we;
        sd_we_q <= (gnt_nxt != GNT_NONE) && sel_we;
        if (gnt_nxt != GNT_NONE) begin
          sd_addr_q <= sel_addr;
          sd_din_q  <= sel_din;
          sd_ds_q   <= sel_ds;
        end
      end
      if (cap_edge && gnt != GNT_NONE && sd_oe_q) rdata_q <= bus.sd_dout_i;
    end
  end

  assign bus.p0_ack    = ack_q[0];
  assign bus.p1_ack    = ack_q[1];
  assign bus.p2_ack    = ack_q[2];
  assign bus.rdata     = rdata_q;
  assign bus.sd_addr_o = sd_addr_q;
  assign bus.sd_din_o  = sd_din_q;
  assign bus.sd_ds_o   = sd_ds_q;
  assign bus.sd_oe_o   = sd_oe_q;
  assign bus.sd_we_o   = sd_we_q;
endmodule
